// File: rtl/exec_engine_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_engine_ctrl_pkg                                                  |
// | Shared opcodes, FSM states, instruction field layout and control type |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package exec_engine_ctrl_pkg;

  localparam int INST_BITS = 9;
  localparam int FIELD_W   = 3;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int FA_MSB  = 5;
  localparam int FA_LSB  = 3;
  localparam int FB_MSB  = 2;
  localparam int FB_LSB  = 0;

  typedef logic [FIELD_W-1:0] opcode_t;
  typedef logic [FIELD_W-1:0] field_t;

  localparam opcode_t OP_NOP   = 3'd0;
  localparam opcode_t OP_LOAD  = 3'd1;
  localparam opcode_t OP_ALU2  = 3'd2;
  localparam opcode_t OP_ALU3  = 3'd3;
  localparam opcode_t OP_ALU4  = 3'd4;
  localparam opcode_t OP_ALU5  = 3'd5;
  localparam opcode_t OP_ALU6  = 3'd6;
  localparam opcode_t OP_STORE = 3'd7;

  typedef logic [0:0] state_t;
  localparam state_t FETCH   = 1'b0;
  localparam state_t EXECUTE = 1'b1;

  typedef struct packed {
    logic    n_mem_en;
    logic    n_alu_en;
    logic    mem_rw;
    opcode_t op_sel;
    field_t  mem_addr;
    field_t  alu_addr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    n_mem_en: 1'b1,
    n_alu_en: 1'b1,
    mem_rw:   1'b1,
    op_sel:   OP_NOP,
    mem_addr: 3'd0,
    alu_addr: 3'd0
  };

endpackage
`default_nettype wire

// File: rtl/exec_engine_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_engine_decoder                                                   |
// | Combinational map from (state, IR) to the matrix engine control lines |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module exec_engine_decoder
  import exec_engine_ctrl_pkg::*;
(
  input  state_t               i_state,
  input  logic [INST_BITS-1:0] i_ir,
  output logic                 o_n_mem_en,
  output logic                 o_n_alu_en,
  output logic                 o_mem_rw,
  output logic [2:0]           o_op_sel,
  output logic [2:0]           o_mem_addr,
  output logic [2:0]           o_alu_addr
);

  opcode_t w_opc;
  field_t  w_fa;
  field_t  w_fb;
  ctrl_t   w_ctrl;

  assign w_opc = i_ir[OPC_MSB:OPC_LSB];
  assign w_fa  = i_ir[FA_MSB:FA_LSB];
  assign w_fb  = i_ir[FB_MSB:FB_LSB];

  // Outside EXECUTE, and for NOP, every control line sits at its idle level.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (i_state == EXECUTE) begin
      case (w_opc)
        OP_NOP: w_ctrl = CTRL_IDLE;
        OP_STORE: begin
          w_ctrl.n_mem_en = 1'b0;
          w_ctrl.n_alu_en = 1'b0;
          w_ctrl.mem_rw   = 1'b0;
          w_ctrl.op_sel   = OP_STORE;
          w_ctrl.mem_addr = w_fb;
          w_ctrl.alu_addr = w_fa;
        end
        default: begin
          // LOAD and ALU ops 2..6 read memory and pass the opcode straight through.
          w_ctrl.n_mem_en = 1'b0;
          w_ctrl.n_alu_en = 1'b0;
          w_ctrl.mem_rw   = 1'b1;
          w_ctrl.op_sel   = w_opc;
          w_ctrl.mem_addr = w_fb;
          w_ctrl.alu_addr = w_fa;
        end
      endcase
    end
  end

  assign o_n_mem_en = w_ctrl.n_mem_en;
  assign o_n_alu_en = w_ctrl.n_alu_en;
  assign o_mem_rw   = w_ctrl.mem_rw;
  assign o_op_sel   = w_ctrl.op_sel;
  assign o_mem_addr = w_ctrl.mem_addr;
  assign o_alu_addr = w_ctrl.alu_addr;

endmodule
`default_nettype wire

// File: rtl/exec_engine_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_engine_ctrl                                                      |
// | Two-clock FETCH/EXECUTE sequencer with PC, IR and Moore control decode|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module exec_engine_ctrl
  import exec_engine_ctrl_pkg::*;
#(
  parameter int PC_W   = 6,
  parameter int INST_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst_mem,
  output logic [PC_W-1:0]   program_address,
  output logic              nMem_Enable,
  output logic              nALU_Enable,
  output logic              mem_RW,
  output logic [2:0]        op_select,
  output logic [2:0]        mem_address,
  output logic [2:0]        ALU_address
);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_ir;

  // inst_mem is only sampled on the FETCH edge; the PC moves only on EXECUTE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir    <= inst_mem;
          r_state <= EXECUTE;
        end
        default: begin
          r_pc    <= r_pc + PC_W'(1);
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign program_address = r_pc;

  exec_engine_decoder u_decoder (
    .i_state    (r_state),
    .i_ir       (r_ir),
    .o_n_mem_en (nMem_Enable),
    .o_n_alu_en (nALU_Enable),
    .o_mem_rw   (mem_RW),
    .o_op_sel   (op_select),
    .o_mem_addr (mem_address),
    .o_alu_addr (ALU_address)
  );

endmodule
`default_nettype wire

// File: tb/tb_exec_engine_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_engine_ctrl                                                   |
// | Directed self-checking bench for the FETCH/EXECUTE sequencer          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_exec_engine_ctrl;

  logic       clk;
  logic       reset;
  logic [8:0] inst_mem;
  logic [5:0] program_address;
  logic       nMem_Enable;
  logic       nALU_Enable;
  logic       mem_RW;
  logic [2:0] op_select;
  logic [2:0] mem_address;
  logic [2:0] ALU_address;

  int n_pass;
  int n_total;

  // Control bundle {nMem, nALU, RW, op, mem_addr, alu_addr}
  logic [11:0] ctl;
  localparam logic [11:0] IDLE = {1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0};

  assign ctl = {nMem_Enable, nALU_Enable, mem_RW, op_select, mem_address, ALU_address};

  exec_engine_ctrl #(.PC_W(6), .INST_W(9)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_mem        (inst_mem),
    .program_address (program_address),
    .nMem_Enable     (nMem_Enable),
    .nALU_Enable     (nALU_Enable),
    .mem_RW          (mem_RW),
    .op_select       (op_select),
    .mem_address     (mem_address),
    .ALU_address     (ALU_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each test after the reset one starts inside a FETCH period.
  task automatic test_reset();
    reset    = 1'b1;
    inst_mem = 9'o000;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    inst_mem = 9'o012;
    reset    = 1'b1;
    #1;
    n_total++;
    if (program_address !== 6'd0) $display("FAIL reset_pc: got %0d want 0", program_address);
    else n_pass++;
    n_total++;
    if (ctl !== IDLE) $display("FAIL reset_idle: got %h want %h", ctl, IDLE);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (ctl !== IDLE || program_address !== 6'd0)
      $display("FAIL reset_nop_exec: got ctl=%h pc=%0d want ctl=%h pc=0", ctl, program_address, IDLE);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ctl !== IDLE || program_address !== 6'd1)
      $display("FAIL reset_first_step: got ctl=%h pc=%0d want ctl=%h pc=1", ctl, program_address, IDLE);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [11:0] exp;
    exp = {1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd6};
    inst_mem = 9'o162;
    @(posedge clk); #1;
    inst_mem = 9'o000;
    n_total++;
    if (ctl !== exp || program_address !== 6'd1)
      $display("FAIL load_162: got ctl=%h pc=%0d want ctl=%h pc=1", ctl, program_address, exp);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ctl !== IDLE || program_address !== 6'd2)
      $display("FAIL load_fetch: got ctl=%h pc=%0d want ctl=%h pc=2", ctl, program_address, IDLE);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [8:0]  insts [4];
    logic [11:0] exps  [4];
    insts[0] = 9'o245; exps[0] = {1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 3'd4};
    insts[1] = 9'o725; exps[1] = {1'b0, 1'b0, 1'b0, 3'd7, 3'd5, 3'd2};
    insts[2] = 9'o434; exps[2] = {1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd3};
    insts[3] = 9'o177; exps[3] = {1'b0, 1'b0, 1'b1, 3'd1, 3'd7, 3'd7};
    for (int i = 0; i < 4; i++) begin
      inst_mem = insts[i];
      @(posedge clk); #1;
      inst_mem = 9'o700;
      n_total++;
      if (ctl !== exps[i] || program_address !== 6'(2 + i))
        $display("FAIL seq_exec_%0d: got ctl=%h pc=%0d want ctl=%h pc=%0d",
                 i, ctl, program_address, exps[i], 2 + i);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (ctl !== IDLE || program_address !== 6'(3 + i))
        $display("FAIL seq_fetch_%0d: got ctl=%h pc=%0d want ctl=%h pc=%0d",
                 i, ctl, program_address, IDLE, 3 + i);
      else n_pass++;
    end
  endtask

  task automatic test_ir_hold();
    logic [11:0] exp;
    exp = {1'b0, 1'b0, 1'b1, 3'd5, 3'd6, 3'd3};
    inst_mem = 9'o536;
    @(posedge clk); #1;
    inst_mem = 9'o000;
    #3;
    n_total++;
    if (ctl !== exp || program_address !== 6'd6)
      $display("FAIL ir_hold: got ctl=%h pc=%0d want ctl=%h pc=6", ctl, program_address, exp);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (ctl !== IDLE || program_address !== 6'd7)
      $display("FAIL ir_next_nop: got ctl=%h pc=%0d want ctl=%h pc=7", ctl, program_address, IDLE);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (program_address !== 6'd8)
      $display("FAIL ir_next_step: got pc=%0d want 8", program_address);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [5:0] exp_pc;
    logic       saw_wrap;
    exp_pc   = 6'd8;
    saw_wrap = 1'b0;
    for (int i = 0; i < 64; i++) begin
      inst_mem = (i % 2 == 0) ? 9'o000 : 9'o077;
      @(posedge clk); #1;
      n_total++;
      if (ctl !== IDLE || program_address !== exp_pc)
        $display("FAIL wrap_exec_%0d: got ctl=%h pc=%0d want ctl=%h pc=%0d",
                 i, ctl, program_address, IDLE, exp_pc);
      else n_pass++;
      @(posedge clk); #1;
      if (exp_pc == 6'd63) begin
        saw_wrap = 1'b1;
        n_total++;
        if (program_address !== 6'd0)
          $display("FAIL wrap_63_to_0: got pc=%0d want 0", program_address);
        else n_pass++;
      end
      exp_pc = exp_pc + 6'd1;
    end
    n_total++;
    if (program_address !== 6'd8 || !saw_wrap)
      $display("FAIL wrap_end: got pc=%0d wrap=%0b want pc=8 wrap=1", program_address, saw_wrap);
    else n_pass++;
  endtask

  task automatic test_reset_store();
    logic [11:0] exp_st;
    logic [11:0] exp_ld;
    exp_st = {1'b0, 1'b0, 1'b0, 3'd7, 3'd3, 3'd1};
    exp_ld = {1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd6};
    inst_mem = 9'o713;
    @(posedge clk); #1;
    n_total++;
    if (ctl !== exp_st || program_address !== 6'd8)
      $display("FAIL store_exec: got ctl=%h pc=%0d want ctl=%h pc=8", ctl, program_address, exp_st);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (ctl !== IDLE || program_address !== 6'd0)
      $display("FAIL store_abort: got ctl=%h pc=%0d want ctl=%h pc=0", ctl, program_address, IDLE);
    else n_pass++;
    @(negedge clk);
    reset    = 1'b0;
    inst_mem = 9'o162;
    @(posedge clk); #1;
    inst_mem = 9'o000;
    n_total++;
    if (ctl !== exp_ld || program_address !== 6'd0)
      $display("FAIL restart_exec: got ctl=%h pc=%0d want ctl=%h pc=0", ctl, program_address, exp_ld);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ctl !== IDLE || program_address !== 6'd1)
      $display("FAIL restart_step: got ctl=%h pc=%0d want ctl=%h pc=1", ctl, program_address, IDLE);
    else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    inst_mem = 9'o000;
    test_reset();
    test_load();
    test_sequence();
    test_ir_hold();
    test_wrap();
    test_reset_store();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
